disparity_hole_fill: RTL and testbench

- Sits directly downstream of the 3x1 bilateral filter and consumes its disparity/confidence/gray pixel stream.
- Rejects low-confidence disparities and fills short holes with the last accepted disparity on the same line.
- Regenerates line/frame markers by counting pixels, since the upstream stream carries none.
- Buffers pixels in a small FIFO and presents them on a ready/valid interface to the frame-buffer writer. Upstream cannot be stalled, so overflow is detected and flagged.

---
 rtl/dispfilt_pkg.sv | 15 +
 rtl/disp_pixel_fifo.sv | 73 +++++++
 rtl/disparity_hole_fill.sv | 199 +++++++++++++++++++
 tb/tb_disparity_hole_fill.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dispfilt_pkg.sv
// Shared types for the disparity filtering pipeline: the pixel word carried
// between stages and the disparity code that marks an unknown depth.
package dispfilt_pkg;

  typedef struct packed {
    logic [7:0] disparity;
    logic [7:0] gray;
    logic       sof;
    logic       eol;
    logic       eof;
  } disp_pix_t;

  localparam logic [7:0] DISP_UNKNOWN = 8'd0;

endpackage

// File: rtl/disp_pixel_fifo.sv
// Synchronous first-word-fall-through FIFO of disp_pix_t.
// The head entry is visible on rd_data whenever empty is low. A write into a
// full FIFO is dropped unless a read frees a slot in the same cycle, and such
// a drop sets the sticky overflow flag until reset.
module disp_pixel_fifo
  import dispfilt_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  disp_pix_t     wr_data,
  input  logic          rd_en,
  output disp_pix_t     rd_data,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count,
  output logic          overflow
);

  disp_pix_t     mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic          overflow_r;
  logic          push_s;
  logic          pop_s;

  // Decide which of the requested push/pop actually happen this cycle.
  always_comb begin
    pop_s  = rd_en && (count_r != {CW{1'b0}});
    push_s = wr_en && ((count_r != CW'(DEPTH)) || pop_s);
  end

  // Storage, pointers, occupancy and the sticky drop flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
      wr_ptr_r   <= {AW{1'b0}};
      rd_ptr_r   <= {AW{1'b0}};
      count_r    <= {CW{1'b0}};
      overflow_r <= 1'b0;
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= wr_data;
        wr_ptr_r        <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
      if (wr_en && !push_s) begin
        overflow_r <= 1'b1;
      end
    end
  end

  assign rd_data  = mem_r[rd_ptr_r];
  assign full     = (count_r == CW'(DEPTH));
  assign empty    = (count_r == {CW{1'b0}});
  assign count    = count_r;
  assign overflow = overflow_r;

endmodule

// File: rtl/disparity_hole_fill.sv
// Confidence gating and short-hole filling for the filtered disparity stream.
// Low-confidence pixels take the last accepted disparity of the same line for
// up to MAX_FILL_RUN pixels, then fall back to DISP_UNKNOWN. Frame/line
// markers are rebuilt from pixel counters, and the result is buffered in a
// FWFT FIFO because the upstream filter cannot be stalled.
// Optional build macro HOLE_FILL_STATS_EN adds per-frame filled/rejected
// pixel counts on filled_count / rejected_count.
module disparity_hole_fill
  import dispfilt_pkg::*;
#(
  parameter int IMG_WIDTH      = 640,
  parameter int IMG_HEIGHT     = 480,
  parameter int CONF_THRESHOLD = 16,
  parameter int MAX_FILL_RUN   = 15,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  disparity_in,
  input  logic [7:0]  confidence_in,
  input  logic [7:0]  gray_in,
  input  logic        in_valid,
  output logic [7:0]  out_disparity,
  output logic [7:0]  out_gray,
  output logic        out_sof,
  output logic        out_eol,
  output logic        out_eof,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        overflow
`ifdef HOLE_FILL_STATS_EN
  ,
  output logic [19:0] filled_count,
  output logic [19:0] rejected_count
`endif
);

  localparam int XW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam int YW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam int RW = (MAX_FILL_RUN > 1) ? $clog2(MAX_FILL_RUN + 1) : 1;
  localparam int FCW = ((FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1) + 1;

  localparam logic [XW-1:0] X_LAST   = XW'(IMG_WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST   = YW'(IMG_HEIGHT - 1);
  localparam logic [RW-1:0] RUN_MAX  = RW'(MAX_FILL_RUN);
  localparam logic [7:0]    CONF_THR = 8'(CONF_THRESHOLD);

  logic [XW-1:0] x_r;
  logic [YW-1:0] y_r;
  logic [7:0]    last_disp_r;
  logic          have_last_r;
  logic [RW-1:0] run_r;
  logic          s1_valid_r;
  disp_pix_t     s1_word_r;

  logic          have_eff_s;
  logic [RW-1:0] run_eff_s;
  logic          accept_s;
  logic          fill_s;
  logic [7:0]    disp_s;
  logic [RW-1:0] run_next_s;
  logic          sof_s;
  logic          eol_s;
  logic          eof_s;

  disp_pix_t      head_s;
  logic           fifo_full_s;
  logic           fifo_empty_s;
  logic [FCW-1:0] fifo_count_s;
  logic           unused_fifo_s;

  // Marker flags come from the position of the incoming pixel.
  always_comb begin
    sof_s = (x_r == {XW{1'b0}}) && (y_r == {YW{1'b0}});
    eol_s = (x_r == X_LAST);
    eof_s = eol_s && (y_r == Y_LAST);
  end

  // Accept/fill/zero decision; fill history is ignored at the start of a line.
  always_comb begin
    if (x_r == {XW{1'b0}}) begin
      have_eff_s = 1'b0;
      run_eff_s  = {RW{1'b0}};
    end else begin
      have_eff_s = have_last_r;
      run_eff_s  = run_r;
    end
    accept_s   = (confidence_in >= CONF_THR);
    fill_s     = 1'b0;
    disp_s     = DISP_UNKNOWN;
    run_next_s = run_eff_s;
    if (accept_s) begin
      disp_s     = disparity_in;
      run_next_s = {RW{1'b0}};
    end else if (have_eff_s && (run_eff_s < RUN_MAX)) begin
      disp_s     = last_disp_r;
      fill_s     = 1'b1;
      run_next_s = run_eff_s + RW'(1);
    end else begin
      disp_s = DISP_UNKNOWN;
      if (run_eff_s < RUN_MAX) begin
        run_next_s = run_eff_s + RW'(1);
      end else begin
        run_next_s = RUN_MAX;
      end
    end
  end

  // Stage 1: position counters, fill history and the registered pixel word.
  always_ff @(posedge clk) begin
    if (reset) begin
      x_r         <= {XW{1'b0}};
      y_r         <= {YW{1'b0}};
      last_disp_r <= 8'd0;
      have_last_r <= 1'b0;
      run_r       <= {RW{1'b0}};
      s1_valid_r  <= 1'b0;
      s1_word_r   <= '0;
    end else begin
      s1_valid_r <= in_valid;
      if (in_valid) begin
        s1_word_r.disparity <= disp_s;
        s1_word_r.gray      <= gray_in;
        s1_word_r.sof       <= sof_s;
        s1_word_r.eol       <= eol_s;
        s1_word_r.eof       <= eof_s;
        if (accept_s) begin
          last_disp_r <= disparity_in;
        end
        have_last_r <= accept_s | have_eff_s;
        run_r       <= run_next_s;
        if (eol_s) begin
          x_r <= {XW{1'b0}};
          y_r <= eof_s ? {YW{1'b0}} : (y_r + YW'(1));
        end else begin
          x_r <= x_r + XW'(1);
        end
      end
    end
  end

`ifdef HOLE_FILL_STATS_EN
  logic [19:0] fill_cnt_r;
  logic [19:0] rej_cnt_r;
  logic [19:0] fill_inc_s;
  logic [19:0] rej_inc_s;

  // Per-pixel contributions to the frame statistics.
  always_comb begin
    fill_inc_s = fill_s ? 20'd1 : 20'd0;
    rej_inc_s  = (!accept_s && !fill_s) ? 20'd1 : 20'd0;
  end

  // Accumulate per frame and publish the totals as the eof pixel is processed.
  always_ff @(posedge clk) begin
    if (reset) begin
      fill_cnt_r     <= 20'd0;
      rej_cnt_r      <= 20'd0;
      filled_count   <= 20'd0;
      rejected_count <= 20'd0;
    end else if (in_valid) begin
      if (eof_s) begin
        filled_count   <= fill_cnt_r + fill_inc_s;
        rejected_count <= rej_cnt_r + rej_inc_s;
        fill_cnt_r     <= 20'd0;
        rej_cnt_r      <= 20'd0;
      end else begin
        fill_cnt_r <= fill_cnt_r + fill_inc_s;
        rej_cnt_r  <= rej_cnt_r + rej_inc_s;
      end
    end
  end
`endif

  disp_pixel_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (s1_valid_r),
    .wr_data  (s1_word_r),
    .rd_en    (out_ready),
    .rd_data  (head_s),
    .full     (fifo_full_s),
    .empty    (fifo_empty_s),
    .count    (fifo_count_s),
    .overflow (overflow)
  );

  assign unused_fifo_s = ^{fifo_full_s, fifo_count_s};

  assign out_valid     = !fifo_empty_s;
  assign out_disparity = head_s.disparity;
  assign out_gray      = head_s.gray;
  assign out_sof       = head_s.sof;
  assign out_eol       = head_s.eol;
  assign out_eof       = head_s.eof;

endmodule

// File: tb/tb_disparity_hole_fill.sv
// Self-checking bench for disparity_hole_fill on a 4x2 image.
// Expected outputs come from a line-history reference model plus a queue
// standing in for the output buffer; directed steps add fixed expectations.
module tb_disparity_hole_fill;
  import dispfilt_pkg::*;

  localparam int W     = 4;
  localparam int H     = 2;
  localparam int THR   = 16;
  localparam int MAXR  = 2;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] disparity_in;
  logic [7:0] confidence_in;
  logic [7:0] gray_in;
  logic       in_valid;
  logic [7:0] out_disparity;
  logic [7:0] out_gray;
  logic       out_sof;
  logic       out_eol;
  logic       out_eof;
  logic       out_valid;
  logic       out_ready;
  logic       overflow;
`ifdef HOLE_FILL_STATS_EN
  logic [19:0] filled_count;
  logic [19:0] rejected_count;
`endif

  always #5 clk = ~clk;

  disparity_hole_fill #(
    .IMG_WIDTH(W), .IMG_HEIGHT(H), .CONF_THRESHOLD(THR),
    .MAX_FILL_RUN(MAXR), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset(reset),
    .disparity_in(disparity_in), .confidence_in(confidence_in), .gray_in(gray_in),
    .in_valid(in_valid),
    .out_disparity(out_disparity), .out_gray(out_gray),
    .out_sof(out_sof), .out_eol(out_eol), .out_eof(out_eof),
    .out_valid(out_valid), .out_ready(out_ready), .overflow(overflow)
`ifdef HOLE_FILL_STATS_EN
    , .filled_count(filled_count), .rejected_count(rejected_count)
`endif
  );

  int checks   = 0;
  int failures = 0;

  // Reference model state
  disp_pix_t  mq[$];
  disp_pix_t  got_w[$];
  disp_pix_t  pend_w;
  logic       pend_v = 1'b0;
  logic       m_ovf  = 1'b0;
  int         pix_idx = 0;
  logic [7:0] line_disp[W];
  logic       line_acc[W];
  logic [7:0] exp_d[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Expected word for one input pixel, derived from its frame position and
  // the accepted pixels earlier in the same line.
  task automatic model_pixel(input logic [7:0] conf, input logic [7:0] disp,
                             input logic [7:0] gray, output disp_pix_t w);
    int x, y, rej;
    bit found;
    logic [7:0] d;
    x = pix_idx % W;
    y = (pix_idx / W) % H;
    w.sof  = (x == 0 && y == 0);
    w.eol  = (x == W - 1);
    w.eof  = (x == W - 1 && y == H - 1);
    w.gray = gray;
    d = 8'd0;
    if (int'(conf) >= THR) begin
      d = disp;
    end else begin
      rej = 0;
      found = 1'b0;
      for (int k = x - 1; k >= 0 && !found; k--) begin
        if (line_acc[k]) begin
          found = 1'b1;
          if (rej < MAXR) d = line_disp[k];
        end else begin
          rej++;
        end
      end
    end
    line_acc[x]  = (int'(conf) >= THR);
    line_disp[x] = disp;
    w.disparity  = d;
    pix_idx = (pix_idx + 1) % (W * H);
  endtask

  // One clock: drive inputs, advance the model across the edge, check outputs.
  task automatic tick(input logic v, input logic [7:0] conf, input logic [7:0] disp,
                      input logic [7:0] gray, input logic rdy, input logic rst);
    disp_pix_t obs;
    reset = rst; in_valid = v; confidence_in = conf;
    disparity_in = disp; gray_in = gray; out_ready = rdy;
    @(posedge clk);
    if (rst) begin
      mq.delete();
      pend_v  = 1'b0;
      m_ovf   = 1'b0;
      pix_idx = 0;
    end else begin
      if (mq.size() > 0 && rdy) got_w.push_back(mq.pop_front());
      if (pend_v) begin
        if (mq.size() < DEPTH) mq.push_back(pend_w);
        else m_ovf = 1'b1;
      end
      pend_v = v;
      if (v) model_pixel(conf, disp, gray, pend_w);
    end
    #1;
    chk("out_valid", 32'(out_valid), 32'(mq.size() > 0));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    if (mq.size() > 0) begin
      obs.disparity = out_disparity; obs.gray = out_gray;
      obs.sof = out_sof; obs.eol = out_eol; obs.eof = out_eof;
      chk("head", 32'(obs), 32'(mq[0]));
    end
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) tick(1'b0, 8'd0, 8'd0, 8'd0, rdy, 1'b0);
  endtask

  // Compare popped disparities against exp_d.
  task automatic check_seq(input string tag);
    chk({tag, "_len"}, 32'(got_w.size()), 32'(exp_d.size()));
    for (int i = 0; i < exp_d.size() && i < got_w.size(); i++)
      chk(tag, 32'(got_w[i].disparity), 32'(exp_d[i]));
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; confidence_in = 8'd0;
    disparity_in = 8'd0; gray_in = 8'd0; out_ready = 1'b0;

    // Reset state
    tick(1'b0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b1);
    tick(1'b0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b1);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_disp", 32'(out_disparity), 32'd0);
    chk("rst_sof", 32'(out_sof), 32'd0);

    // Full frame of accepted pixels, disparity = index
    got_w.delete();
    tick(1'b1, 8'd20, 8'd0, 8'd100, 1'b1, 1'b0);
    chk("lat_first", 32'(out_valid), 32'd0);
    tick(1'b1, 8'd20, 8'd1, 8'd101, 1'b1, 1'b0);
    chk("lat_second", 32'(out_valid), 32'd1);
    chk("lat_disp", 32'(out_disparity), 32'd0);
    chk("lat_sof", 32'(out_sof), 32'd1);
    for (int i = 2; i < 8; i++) tick(1'b1, 8'd20, 8'(i), 8'(100 + i), 1'b1, 1'b0);
    idle(3, 1'b1);
    exp_d = {8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7};
    check_seq("frame_disp");
    if (got_w.size() == 8) begin
      for (int i = 0; i < 8; i++) begin
        chk("frame_sof", 32'(got_w[i].sof), 32'(i == 0));
        chk("frame_eol", 32'(got_w[i].eol), 32'(i == 3 || i == 7));
        chk("frame_eof", 32'(got_w[i].eof), 32'(i == 7));
      end
    end

    // Hole between accepted pixels is filled
    got_w.delete();
    tick(1'b1, 8'd20, 8'd9, 8'd1, 1'b1, 1'b0);
    tick(1'b1, 8'd5,  8'd1, 8'd2, 1'b1, 1'b0);
    tick(1'b1, 8'd5,  8'd2, 8'd3, 1'b1, 1'b0);
    tick(1'b1, 8'd20, 8'd7, 8'd4, 1'b1, 1'b0);
    // Run longer than MAX_FILL_RUN falls back to unknown
    tick(1'b1, 8'd20, 8'd3, 8'd5, 1'b1, 1'b0);
    tick(1'b1, 8'd5,  8'd50, 8'd6, 1'b1, 1'b0);
    tick(1'b1, 8'd15, 8'd51, 8'd7, 1'b1, 1'b0);
    tick(1'b1, 8'd0,  8'd52, 8'd8, 1'b1, 1'b0);
    // No carry of the last accepted value into the next line
    tick(1'b1, 8'd20, 8'd1, 8'd9, 1'b1, 1'b0);
    tick(1'b1, 8'd16, 8'd2, 8'd9, 1'b1, 1'b0);
    tick(1'b1, 8'd20, 8'd3, 8'd9, 1'b1, 1'b0);
    tick(1'b1, 8'd20, 8'd12, 8'd9, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) tick(1'b1, 8'd5, 8'd77, 8'd9, 1'b1, 1'b0);
    idle(3, 1'b1);
    exp_d = {8'd9, 8'd9, 8'd9, 8'd7, 8'd3, 8'd3, 8'd3, 8'd0,
             8'd1, 8'd2, 8'd3, 8'd12, 8'd0, 8'd0, 8'd0, 8'd0};
    check_seq("fill_disp");

    // Overflow with a stalled consumer
    tick(1'b0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b1);
    got_w.delete();
    for (int i = 0; i < 5; i++) tick(1'b1, 8'd20, 8'(40 + i), 8'(200 + i), 1'b0, 1'b0);
    chk("ovf_before", 32'(overflow), 32'd0);
    tick(1'b1, 8'd20, 8'd45, 8'd205, 1'b0, 1'b0);
    chk("ovf_after", 32'(overflow), 32'd1);
    for (int i = 0; i < 2; i++) begin
      tick(1'b0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0);
      chk("stall_head", 32'(out_disparity), 32'd40);
      chk("stall_gray", 32'(out_gray), 32'd200);
    end
    idle(5, 1'b1);
    exp_d = {8'd40, 8'd41, 8'd42, 8'd43};
    check_seq("ovf_disp");
    chk("ovf_sticky", 32'(overflow), 32'd1);

    // Reset mid-frame while data is buffered
    for (int i = 0; i < 5; i++) tick(1'b1, 8'd20, 8'(60 + i), 8'd0, 1'b0, 1'b0);
    tick(1'b0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b1);
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_ovf", 32'(overflow), 32'd0);
    tick(1'b1, 8'd5, 8'd88, 8'd33, 1'b1, 1'b0);
    tick(1'b0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0);
    chk("post_rst_sof", 32'(out_sof), 32'd1);
    chk("post_rst_disp", 32'(out_disparity), 32'd0);
    idle(2, 1'b1);

    // Randomised traffic against the model
    tick(1'b0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b1);
    for (int i = 0; i < 400; i++) begin
      tick(1'b1 && ($urandom_range(3, 0) != 0), 8'($urandom_range(31, 0)),
           8'($urandom_range(255, 0)), 8'($urandom_range(255, 0)),
           1'b1 && ($urandom_range(9, 0) < 7), 1'b0);
    end
    idle(8, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
